// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for a Sobel kernel: two line buffers plus a
// 3x3 shift register, emitting one interior window per accepted pixel.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic [23:0] row1,
    output logic [23:0] row2,
    output logic [23:0] row3,
    output logic        win_valid,
    output logic        win_last,
    input  logic        win_ready
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [7:0]    lb0_mem [IMG_WIDTH];
    logic [7:0]    lb1_mem [IMG_WIDTH];

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [23:0]   top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic [23:0]   row1_q, row1_d, row2_q, row2_d, row3_q, row3_d;
    logic          win_valid_q, win_valid_d;
    logic          win_last_q, win_last_d;

    logic          accept_s;
    logic          win_done_s;
    logic [CW-1:0] col_cur_s;
    logic [RW-1:0] row_cur_s;
    logic [7:0]    lb0_rd_s, lb1_rd_s;

    assign pix_ready = !win_valid_q || win_ready;
    assign accept_s  = pix_valid && pix_ready;

    // A start-of-frame pixel is always position (0,0), whatever the counters say.
    assign col_cur_s  = pix_sof ? {CW{1'b0}} : col_q;
    assign row_cur_s  = pix_sof ? {RW{1'b0}} : row_q;
    assign lb0_rd_s   = lb0_mem[col_cur_s];
    assign lb1_rd_s   = lb1_mem[col_cur_s];
    assign win_done_s = accept_s && (row_cur_s >= RW'(2)) && (col_cur_s >= CW'(2));

    // Next-state logic for counters, window shift registers and output register.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        top_d       = top_q;
        mid_d       = mid_q;
        bot_d       = bot_q;
        row1_d      = row1_q;
        row2_d      = row2_q;
        row3_d      = row3_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;

        if (accept_s) begin
            top_d = {top_q[15:0], lb1_rd_s};
            mid_d = {mid_q[15:0], lb0_rd_s};
            bot_d = {bot_q[15:0], pix_in};
            if (col_cur_s == COL_LAST) begin
                col_d = {CW{1'b0}};
                row_d = (row_cur_s == ROW_LAST) ? {RW{1'b0}} : row_cur_s + RW'(1);
            end else begin
                col_d = col_cur_s + CW'(1);
                row_d = row_cur_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end

        // A new window may replace the one handed off in this same cycle.
        if (win_done_s) begin
            row1_d      = {top_q[15:0], lb1_rd_s};
            row2_d      = {mid_q[15:0], lb0_rd_s};
            row3_d      = {bot_q[15:0], pix_in};
            win_valid_d = 1'b1;
            win_last_d  = (row_cur_s == ROW_LAST) && (col_cur_s == COL_LAST);
        end else if (win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end else begin
            win_valid_d = win_valid_q;
            win_last_d  = win_last_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= {CW{1'b0}};
            row_q       <= {RW{1'b0}};
            top_q       <= 24'h000000;
            mid_q       <= 24'h000000;
            bot_q       <= 24'h000000;
            row1_q      <= 24'h000000;
            row2_q      <= 24'h000000;
            row3_q      <= 24'h000000;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            top_q       <= top_d;
            mid_q       <= mid_d;
            bot_q       <= bot_d;
            row1_q      <= row1_d;
            row2_q      <= row2_d;
            row3_q      <= row3_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
        end
    end

    // Line buffers age by one line per accept; contents are rewritten before use.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_mem[col_cur_s] <= lb0_rd_s;
            lb0_mem[col_cur_s] <= pix_in;
        end
    end

    assign row1      = row1_q;
    assign row2      = row2_q;
    assign row3      = row3_q;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 image with pixel p(r,c)=10r+c.
module tb_sobel_window_gen;

    localparam int W = 5;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pix_in = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        win_ready = 1'b1;
    logic        pix_ready;
    logic [23:0] row1, row2, row3;
    logic        win_valid, win_last;

    int n_cmp = 0;
    int n_fail = 0;
    logic [72:0] win_q [$];

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_ready(pix_ready), .row1(row1), .row2(row2),
        .row3(row3), .win_valid(win_valid), .win_last(win_last), .win_ready(win_ready)
    );

    always #5 clk = ~clk;

    // Record every window handed off; the handshake completes on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && win_valid && win_ready) win_q.push_back({win_last, row1, row2, row3});
    end

    function automatic logic [7:0] pv(int r, int c);
        return 8'(10 * r + c);
    endfunction

    // Window idx (0..5) of a 5x4 frame, centred at (1 + idx/3, 1 + idx%3).
    function automatic logic [72:0] exp_win(int idx);
        int r, c;
        r = 1 + idx / 3;
        c = 1 + idx % 3;
        return {(idx == 5) ? 1'b1 : 1'b0,
                pv(r-1, c-1), pv(r-1, c), pv(r-1, c+1),
                pv(r,   c-1), pv(r,   c), pv(r,   c+1),
                pv(r+1, c-1), pv(r+1, c), pv(r+1, c+1)};
    endfunction

    task automatic chk(string tag, logic [79:0] obs, logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one pixel (optionally after a random idle gap) and hold it until accepted.
    task automatic send_pix(int r, int c, bit sof, bit gaps);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end
        pix_in = pv(r, c);
        pix_sof = sof;
        pix_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!pix_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) begin
            n_cmp++;
            n_fail++;
            $error("FAIL accept_timeout: pixel (%0d,%0d) pix_ready=%b required 1", r, c, pix_ready);
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    // Stream one full frame, checking emit timing per pixel and the first/last window values.
    task automatic send_frame(string tag, bit sof_first, bit gaps, bit hold_first);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pix(r, c, sof_first && r == 0 && c == 0, gaps);
                chk($sformatf("%s_valid_%0d_%0d", tag, r, c), 80'(win_valid),
                    80'((r >= 2 && c >= 2) ? 1 : 0));
                if (r == 2 && c == 2) begin
                    chk({tag, "_first"}, 80'({win_valid, win_last, row1, row2, row3}),
                        80'({1'b1, 1'b0, 24'h000102, 24'h0A0B0C, 24'h141516}));
                    if (hold_first) begin
                        win_ready = 1'b0;
                        pix_in = pv(2, 3);
                        pix_valid = 1'b1;
                        for (int k = 0; k < 5; k++) begin
                            @(negedge clk);
                            chk($sformatf("%s_hold_%0d", tag, k),
                                80'({pix_ready, win_valid, win_last, row1, row2, row3}),
                                80'({1'b0, 1'b1, 1'b0, 24'h000102, 24'h0A0B0C, 24'h141516}));
                        end
                        @(posedge clk);
                        #1;
                        win_ready = 1'b1;
                    end
                end
                if (r == 3 && c == 4) begin
                    chk({tag, "_last"}, 80'({win_valid, win_last, row1, row2, row3}),
                        80'({1'b1, 1'b1, 24'h0C0D0E, 24'h161718, 24'h202122}));
                end
            end
        end
    endtask

    task automatic check_frame(string tag);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_count"}, 80'(win_q.size()), 80'(6));
        for (int i = 0; i < win_q.size() && i < 6; i++) begin
            chk($sformatf("%s_win%0d", tag, i), 80'(win_q[i]), 80'(exp_win(i)));
        end
        win_q.delete();
    endtask

    initial begin
        // Reset state
        #2;
        chk("reset_outputs", 80'({win_valid, win_last, row1, row2, row3}), 80'(0));
        chk("reset_ready", 80'(pix_ready), 80'(1));
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame, then a second frame without pix_sof
        send_frame("t1", 1'b1, 1'b0, 1'b0);
        check_frame("t1");
        send_frame("t2", 1'b0, 1'b0, 1'b0);
        check_frame("t2");

        // Backpressure on the first window
        send_frame("t3", 1'b0, 1'b0, 1'b1);
        check_frame("t3");

        // Random input gaps
        send_frame("t4", 1'b0, 1'b1, 1'b0);
        check_frame("t4");

        // Partial frame aborted by pix_sof where p(1,3) would be
        for (int c = 0; c < W; c++) send_pix(0, c, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) send_pix(1, c, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_partial_none", 80'(win_q.size()), 80'(0));
        send_frame("t5", 1'b1, 1'b0, 1'b0);
        check_frame("t5");

        // Asynchronous reset while the last window is held
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) send_pix(r, c, 1'b0, 1'b0);
        end
        win_ready = 1'b0;
        @(negedge clk);
        chk("t6_held_last", 80'({win_valid, win_last}), 80'(3));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_clear", 80'({win_valid, win_last, row1, row2, row3}), 80'(0));
        chk("t6_ready", 80'(pix_ready), 80'(1));
        @(negedge clk);
        rst_n = 1'b1;
        win_ready = 1'b1;
        win_q.delete();
        @(posedge clk);
        #1;
        send_frame("t6", 1'b1, 1'b0, 1'b0);
        check_frame("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
